// File: rtl/context_window_gen.sv
// KxK sliding-window generator: K-1 line RAMs, x/y position counters, 2-cycle output pipeline.
// Optional frame-edge zero padding is enabled by defining CONTEXT_ZERO_PAD_EN.

module cwg_line_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 800,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we) mem_q[addr] <= wdata;

    // Asynchronous read gives read-before-write for the cascade on the same edge.
    assign rdata = mem_q[addr];
endmodule

module context_window_gen #(
    parameter int PIX_W  = 8,
    parameter int KSIZE  = 3,
    parameter int H_SIZE = 800,
    parameter int CNT_W  = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PIX_W-1:0]             pixel_in,
    input  logic                         de_in,
    input  logic                         h_sync_in,
    input  logic                         v_sync_in,
    output logic                         win_valid,
    output logic [KSIZE*KSIZE*PIX_W-1:0] win_data,
    output logic [CNT_W-1:0]             center_x,
    output logic [CNT_W-1:0]             center_y,
    output logic                         de_out,
    output logic                         h_sync_out,
    output logic                         v_sync_out,
    output logic                         line_ovf
);
    localparam int H  = (KSIZE - 1) / 2;
    localparam int NR = KSIZE - 1;
    localparam int AW = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;

    typedef logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0] win_t;

    logic [CNT_W-1:0]           x_q, x_d, y_q, y_d;
    logic                       de_prev_q, vs_prev_q, ovf_q;
    logic                       in_range, wr_en, s1_vld_d, s1_vld_q, vld_o_q;
    logic [AW-1:0]              addr;
    logic [NR-1:0][PIX_W-1:0]   rd, wd;
    win_t                       win_q, win_d, win_m, win_o_q;
    logic [CNT_W-1:0]           s1_x_q, s1_y_q, cx_q, cy_q;
    logic [1:0]                 de_pipe_q, hs_pipe_q, vs_pipe_q;

    assign in_range = (x_q < CNT_W'(H_SIZE));
    assign wr_en    = de_in & in_range;
    assign addr     = in_range ? x_q[AW-1:0] : '0;

    // RAM0 takes the new pixel, RAMj+1 takes RAMj's old value: each RAM shifts down one row.
    for (genvar j = 0; j < NR; j++) begin : g_ram
        if (j == 0) begin : g_head
            assign wd[j] = pixel_in;
        end else begin : g_casc
            assign wd[j] = rd[j-1];
        end
        cwg_line_ram #(.W(PIX_W), .DEPTH(H_SIZE), .AW(AW)) u_ram (
            .clk(clk), .we(wr_en), .addr(addr), .wdata(wd[j]), .rdata(rd[j])
        );
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (v_sync_in & ~vs_prev_q) begin
            x_d = '0;
            y_d = '0;
        end else if (de_prev_q & ~de_in) begin
            x_d = '0;
            y_d = (&y_q) ? y_q : y_q + 1'b1;
        end else if (de_in & in_range) begin
            x_d = x_q + 1'b1;
        end
    end

`ifdef CONTEXT_ZERO_PAD_EN
    assign s1_vld_d = de_in & in_range;
`else
    assign s1_vld_d = de_in & in_range & (x_q >= CNT_W'(KSIZE-1)) & (y_q >= CNT_W'(KSIZE-1));
`endif

    always_comb begin
        win_d = win_q;
        if (de_in) begin
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE-1; c++)
                    win_d[r][c] = win_q[r][c+1];
            win_d[KSIZE-1][KSIZE-1] = pixel_in;
            for (int j = 0; j < NR; j++)
                win_d[KSIZE-2-j][KSIZE-1] = rd[j];
        end
    end

    always_comb begin
        win_m = win_q;
`ifdef CONTEXT_ZERO_PAD_EN
        // Taps that fall left of column 0 or above row 0 of the frame read as zero.
        for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
                if ((CNT_W'(KSIZE-1-c) > s1_x_q) || (CNT_W'(KSIZE-1-r) > s1_y_q))
                    win_m[r][c] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            ovf_q     <= 1'b0;
            win_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            de_pipe_q <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            vld_o_q   <= 1'b0;
            win_o_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            de_prev_q <= de_in;
            vs_prev_q <= v_sync_in;
            if (de_in & ~in_range) ovf_q <= 1'b1;
            win_q     <= win_d;
            s1_vld_q  <= s1_vld_d;
            if (de_in) begin
                s1_x_q <= x_q;
                s1_y_q <= y_q;
            end
            de_pipe_q <= {de_pipe_q[0], de_in};
            hs_pipe_q <= {hs_pipe_q[0], h_sync_in};
            vs_pipe_q <= {vs_pipe_q[0], v_sync_in};
            vld_o_q   <= s1_vld_q;
            // Output window only moves on accepted pixels, so it stays frozen across de gaps.
            if (de_pipe_q[0]) begin
                win_o_q <= win_m;
                cx_q    <= s1_x_q - CNT_W'(H);
                cy_q    <= s1_y_q - CNT_W'(H);
            end
        end
    end

    assign win_valid  = vld_o_q;
    assign win_data   = win_o_q;
    assign center_x   = cx_q;
    assign center_y   = cy_q;
    assign de_out     = de_pipe_q[1];
    assign h_sync_out = hs_pipe_q[1];
    assign v_sync_out = vs_pipe_q[1];
    assign line_ovf   = ovf_q;
endmodule

// File: tb/tb_context_window_gen.sv
// Directed-sequence bench with random pixels; expected windows come from a frame-image model.
module tb_context_window_gen;
    localparam int PIX_W  = 8;
    localparam int CNT_W  = 8;
    localparam int H_SIZE = 16;
`ifdef CONTEXT_ZERO_PAD_EN
    localparam int K = 5;
    localparam bit PAD = 1'b1;
`else
    localparam int K = 3;
    localparam bit PAD = 1'b0;
`endif
    localparam int H  = (K - 1) / 2;
    localparam int DW = K * K * PIX_W;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [PIX_W-1:0] pixel_in = '0;
    logic de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
    logic win_valid, de_out, h_sync_out, v_sync_out, line_ovf;
    logic [DW-1:0] win_data;
    logic [CNT_W-1:0] center_x, center_y;

    context_window_gen #(.PIX_W(PIX_W), .KSIZE(K), .H_SIZE(H_SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .de_in(de_in),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .win_valid(win_valid),
        .win_data(win_data), .center_x(center_x), .center_y(center_y),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .line_ovf(line_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [DW-1:0]    data;
        logic [CNT_W-1:0] cx, cy;
        logic             de, hs, vs;
    } exp_t;

    int errors = 0, checks = 0;
    logic [PIX_W-1:0] img [64][32];
    int mx, my, vld_cnt;
    logic de_p, vs_p, m_ovf, cap_seen;
    logic [DW-1:0] cap_data;
    logic [CNT_W-1:0] cap_cx, cap_cy;
    exp_t ep, en;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window centred so that (x,y) is the newest tap; out-of-frame taps read as zero.
    function automatic logic [DW-1:0] mwin(input int x, input int y);
        logic [DW-1:0] w;
        int yy, xx;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                yy = y - (K - 1 - r);
                xx = x - (K - 1 - c);
                if (yy >= 0 && xx >= 0) w[(r*K+c)*PIX_W +: PIX_W] = img[yy][xx];
            end
        return w;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; de_p = 1'b0; vs_p = 1'b0; m_ovf = 1'b0;
        ep.vld = 1'b0; ep.data = '0; ep.cx = '0; ep.cy = '0;
        ep.de = 1'b0; ep.hs = 1'b0; ep.vs = 1'b0;
    endtask

    task automatic step(input logic de, input logic [PIX_W-1:0] pix, input logic hs, input logic vs);
        en.de = de; en.hs = hs; en.vs = vs;
        en.vld = 1'b0; en.data = '0; en.cx = '0; en.cy = '0;
        if (de && mx < H_SIZE) begin
            img[my][mx] = pix;
            en.vld  = PAD || (mx >= K-1 && my >= K-1);
            en.data = mwin(mx, my);
            en.cx   = CNT_W'(mx - H);
            en.cy   = CNT_W'(my - H);
        end
        if (de && mx >= H_SIZE) m_ovf = 1'b1;
        if (vs && !vs_p) begin
            mx = 0; my = 0;
        end else if (de_p && !de) begin
            mx = 0;
            if (my < 255) my++;
        end else if (de && mx < H_SIZE) begin
            mx++;
        end
        de_p = de; vs_p = vs;
        pixel_in = pix; de_in = de; h_sync_in = hs; v_sync_in = vs;
        @(posedge clk); #1;
        chk("win_valid", 256'(win_valid), 256'(ep.vld));
        chk("de_out", 256'(de_out), 256'(ep.de));
        chk("h_sync_out", 256'(h_sync_out), 256'(ep.hs));
        chk("v_sync_out", 256'(v_sync_out), 256'(ep.vs));
        chk("line_ovf", 256'(line_ovf), 256'(m_ovf));
        if (ep.vld) begin
            chk("win_data", 256'(win_data), 256'(ep.data));
            chk("center_x", 256'(center_x), 256'(ep.cx));
            chk("center_y", 256'(center_y), 256'(ep.cy));
        end
        if (win_valid) begin
            vld_cnt++;
            if (!cap_seen) begin
                cap_seen = 1'b1; cap_data = win_data; cap_cx = center_x; cap_cy = center_y;
            end
        end
        ep = en;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, PIX_W'($urandom), 1'b0, 1'b0);
    endtask

    task automatic vsync();
        step(1'b0, PIX_W'($urandom), 1'b0, 1'b1);
        step(1'b0, PIX_W'($urandom), 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic line(input int w, input int ln, input bit ramp, input int blank);
        step(1'b0, PIX_W'($urandom), 1'b1, 1'b0);
        idle(1);
        for (int x = 0; x < w; x++)
            step(1'b1, ramp ? PIX_W'((ln << 4) | x) : PIX_W'($urandom), 1'b0, 1'b0);
        idle(blank);
    endtask

    task automatic frame(input int w, input int h, input bit ramp, input bit rnd_blank);
        vsync();
        for (int y = 0; y < h; y++)
            line(w, y, ramp, rnd_blank ? 1 + int'($urandom % 3) : 2);
        idle(3);
    endtask

    initial begin
        model_reset();
        vld_cnt = 0; cap_seen = 1'b0; cap_data = '0; cap_cx = '0; cap_cy = '0;
        @(posedge clk); #1;
        chk("rst_win_valid", 256'(win_valid), 256'(0));
        chk("rst_win_data", 256'(win_data), 256'(0));
        chk("rst_line_ovf", 256'(line_ovf), 256'(0));
        chk("rst_de_out", 256'(de_out), 256'(0));
        rst_n = 1'b1;

        // Ramp frame 8x6
        vld_cnt = 0; cap_seen = 1'b0;
        frame(8, 6, 1'b1, 1'b0);
        chk("t1_valid_count", 256'(vld_cnt), 256'(PAD ? 48 : 24));
        if (!PAD) begin
            chk("t1_center_tap", 256'(cap_data[(H*K+H)*PIX_W +: PIX_W]), 256'(8'h11));
            chk("t1_tap00", 256'(cap_data[PIX_W-1:0]), 256'(0));
            chk("t1_center_xy", 256'({cap_cx, cap_cy}), 256'({8'd1, 8'd1}));
        end

        // Random pixels, variable blanking between lines
        vld_cnt = 0;
        frame(8, 5, 1'b0, 1'b1);
        chk("t2_valid_count", 256'(vld_cnt), 256'(PAD ? 40 : 18));

        // Overflow: 20-pixel lines into 16-deep RAMs
        chk("t3_ovf_before", 256'(line_ovf), 256'(0));
        vld_cnt = 0;
        frame(20, 4, 1'b0, 1'b0);
        chk("t3_valid_count", 256'(vld_cnt), 256'(PAD ? 64 : 28));
        chk("t3_ovf_after", 256'(line_ovf), 256'(1));

        // Asynchronous reset in the middle of line 4
        vsync();
        for (int y = 0; y < 4; y++) line(8, y, 1'b0, 2);
        step(1'b0, PIX_W'($urandom), 1'b1, 1'b0);
        idle(1);
        for (int x = 0; x < 3; x++) step(1'b1, PIX_W'($urandom), 1'b0, 1'b0);
        de_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4_win_valid", 256'(win_valid), 256'(0));
        chk("t4_win_data", 256'(win_data), 256'(0));
        chk("t4_center", 256'({center_x, center_y}), 256'(0));
        chk("t4_syncs", 256'({de_out, h_sync_out, v_sync_out}), 256'(0));
        chk("t4_line_ovf", 256'(line_ovf), 256'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        vld_cnt = 0;
        frame(8, 5, 1'b0, 1'b0);
        chk("t4_valid_count", 256'(vld_cnt), 256'(PAD ? 40 : 18));

        // vsync rise on the same cycle as de fall
        vsync();
        for (int y = 0; y < 2; y++) line(6, y, 1'b0, 2);
        line(6, 2, 1'b0, 0);
        step(1'b0, PIX_W'($urandom), 1'b0, 1'b1);
        step(1'b0, PIX_W'($urandom), 1'b0, 1'b0);
        idle(2);
        vld_cnt = 0;
        for (int y = 0; y < 3; y++) line(6, y, 1'b0, 2);
        idle(3);
        chk("t5_valid_count", 256'(vld_cnt), 256'(PAD ? 18 : 4));

        if (PAD) begin
            vsync();
            cap_seen = 1'b0;
            step(1'b0, PIX_W'($urandom), 1'b1, 1'b0);
            idle(1);
            step(1'b1, 8'hAA, 1'b0, 1'b0);
            for (int x = 1; x < 6; x++) step(1'b1, PIX_W'($urandom), 1'b0, 1'b0);
            idle(3);
            chk("t6_window", 256'(cap_data), 256'(DW'(8'hAA) << ((K*K-1)*PIX_W)));
            chk("t6_center", 256'({cap_cx, cap_cy}), 256'({CNT_W'(-H), CNT_W'(-H)}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
